fetch_stage: RTL

- Instruction-fetch stage of the 5-stage 16-bit RISC pipeline.
- Owns the PC and drives a req/ack instruction-memory port that may have variable latency.
- Loads the IF/ID pipeline register consumed by the decode stage (control unit reads opcode bits [15:13]).
- Handles hazard-unit stalls and branch/jump redirects; injects NOP bubbles.

---
 rtl/pipeline_pkg.sv | 25 ++
 rtl/fetch_stage_if.sv | 14 +
 rtl/if_id_reg.sv | 48 ++++
 rtl/fetch_stage.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the 16-bit RISC pipeline: NOP encoding, opcode
// field position, fetch-stage state encoding and the default reset PC.
package pipeline_pkg;

   // Opcode 101 with all other fields zero; decode treats it as a no-op.
   localparam logic [15:0] NOP_INST         = 16'hA000;
   localparam int          OPCODE_MSB       = 15;
   localparam int          OPCODE_LSB       = 13;
   localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

   // FETCH: request in flight or about to issue
   // HOLD : stalled with the captured instruction parked in the skid register
   // DROP : redirected while a request was outstanding; its data is discarded
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } fetch_state_t;

   // Opcode field as seen by the control unit.
   function automatic logic [2:0] opcode_of(input logic [15:0] inst);
      return inst[OPCODE_MSB:OPCODE_LSB];
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge port. The fetch stage is the master;
// the memory is the slave. A transfer completes on the edge where req & ack.
interface fetch_stage_if #(
   parameter int PC_W   = 16,
   parameter int INST_W = 16
);
   logic              req;
   logic [PC_W-1:0]   addr;
   logic              ack;
   logic [INST_W-1:0] rdata;

   modport master (output req, output addr, input  ack, input  rdata);
   modport slave  (input  req, input  addr, output ack, output rdata);
endinterface

// File: rtl/if_id_reg.sv
// Pipeline register carrying valid/instruction/pc+1 between stages.
// Bubble forces valid=0 and the NOP encoding; hold freezes all fields;
// load captures new contents. Priority: bubble > hold > load.
module if_id_reg
   import pipeline_pkg::*;
#(
   parameter int PC_W   = 16,
   parameter int INST_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic              i_bubble,
   input  logic              i_hold,
   input  logic              i_valid,
   input  logic [INST_W-1:0] i_inst,
   input  logic [PC_W-1:0]   i_pc_plus1,
   output logic              o_valid,
   output logic [INST_W-1:0] o_inst,
   output logic [PC_W-1:0]   o_pc_plus1
);

   logic              r_valid;
   logic [INST_W-1:0] r_inst;
   logic [PC_W-1:0]   r_pc_plus1;

   // Register update: flush to NOP, hold, or load new contents.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         r_valid    <= 1'b0;
         r_inst     <= INST_W'(NOP_INST);
         r_pc_plus1 <= '0;
      end else if (i_bubble) begin
         r_valid <= 1'b0;
         r_inst  <= INST_W'(NOP_INST);
      end else if (i_load && !i_hold) begin
         r_valid    <= i_valid;
         r_inst     <= i_inst;
         r_pc_plus1 <= i_pc_plus1;
      end
   end

   assign o_valid    = r_valid;
   assign o_inst     = r_inst;
   assign o_pc_plus1 = r_pc_plus1;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a variable-latency req/ack
// memory port, and loads the IF/ID register. Stalls park a returning
// instruction in a one-entry skid register; redirects flush fetch and, if a
// request is still outstanding, wait out its ack in DROP before refetching.
module fetch_stage
   import pipeline_pkg::*;
#(
   parameter int              PC_W     = 16,
   parameter int              INST_W   = 16,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst_n,
   fetch_stage_if.master     imem,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              ifid_valid,
   output logic [INST_W-1:0] ifid_inst,
   output logic [PC_W-1:0]   ifid_pc_plus1
);

   fetch_state_t      r_state;
   logic [PC_W-1:0]   r_pc;
   logic [PC_W-1:0]   r_drop_addr;
   logic              r_skid_valid;
   logic [INST_W-1:0] r_skid_inst;
   logic [PC_W-1:0]   r_skid_pc_plus1;

   logic [PC_W-1:0]   w_pc_plus1;
   logic              w_load;
   logic              w_bubble;
   logic              w_hold;
   logic              w_load_valid;
   logic [INST_W-1:0] w_load_inst;
   logic [PC_W-1:0]   w_load_pc_plus1;

   assign w_pc_plus1 = r_pc + PC_W'(1);

   // Request depends on state only; gated low while reset is asserted.
   // In DROP the abandoned address is presented until its ack.
   assign imem.req  = rst_n && (r_state != HOLD);
   assign imem.addr = (r_state == DROP) ? r_drop_addr : r_pc;

   // PC, skid register and state sequencing; redirect has top priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= FETCH;
         r_pc            <= RESET_PC;
         r_drop_addr     <= RESET_PC;
         r_skid_valid    <= 1'b0;
         r_skid_inst     <= INST_W'(NOP_INST);
         r_skid_pc_plus1 <= '0;
      end else if (redirect_valid) begin
         r_pc         <= redirect_pc;
         r_skid_valid <= 1'b0;
         case (r_state)
            FETCH: begin
               if (!imem.ack) begin
                  r_state     <= DROP;
                  r_drop_addr <= r_pc;
               end
            end
            HOLD:    r_state <= FETCH;
            DROP:    r_state <= imem.ack ? FETCH : DROP;
            default: r_state <= FETCH;
         endcase
      end else begin
         case (r_state)
            FETCH: begin
               if (imem.ack) begin
                  r_pc <= w_pc_plus1;
                  if (stall) begin
                     r_skid_valid    <= 1'b1;
                     r_skid_inst     <= imem.rdata;
                     r_skid_pc_plus1 <= w_pc_plus1;
                     r_state         <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (!stall) begin
                  r_skid_valid <= 1'b0;
                  r_state      <= FETCH;
               end
            end
            DROP: begin
               if (imem.ack) r_state <= FETCH;
            end
            default: r_state <= FETCH;
         endcase
      end
   end

   // IF/ID control: choose between bubble, hold, fresh data or skid data.
   always_comb begin
      // NOTE: defaults first so every path assigns every output (no latches).
      w_load          = 1'b0;
      w_bubble        = 1'b0;
      w_hold          = 1'b0;
      w_load_valid    = 1'b1;
      w_load_inst     = imem.rdata;
      w_load_pc_plus1 = w_pc_plus1;
      if (redirect_valid) begin
         w_bubble = 1'b1;
      end else begin
         case (r_state)
            FETCH: begin
               if (stall)          w_hold   = 1'b1;
               else if (imem.ack)  w_load   = 1'b1;
               else                w_bubble = 1'b1;
            end
            HOLD: begin
               if (stall) begin
                  w_hold = 1'b1;
               end else begin
                  w_load          = 1'b1;
                  w_load_valid    = r_skid_valid;
                  w_load_inst     = r_skid_inst;
                  w_load_pc_plus1 = r_skid_pc_plus1;
               end
            end
            default: w_bubble = 1'b1;
         endcase
      end
   end

   if_id_reg #(
      .PC_W   (PC_W),
      .INST_W (INST_W)
   ) u_if_id_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_bubble   (w_bubble),
      .i_hold     (w_hold),
      .i_valid    (w_load_valid),
      .i_inst     (w_load_inst),
      .i_pc_plus1 (w_load_pc_plus1),
      .o_valid    (ifid_valid),
      .o_inst     (ifid_inst),
      .o_pc_plus1 (ifid_pc_plus1)
   );

endmodule
